// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: per-source level/edge latching, mask, and
// optional claim/complete fixed-priority nesting enabled by the INTC_PRIORITY_EN macro.
module int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] HWInt
);

  localparam logic [2:0] NSRC_ID = 3'(NSRC);

  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_irq_d;
  logic [NSRC-1:0] r_isr;

  logic            w_wr;
  logic            w_wr_mask;
  logic            w_wr_mode;
  logic            w_wr_pend;
  logic            w_wr_claim;
  logic [2:0]      w_id;
  logic [NSRC-1:0] w_id_oh;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_act;
  logic [NSRC-1:0] w_blk;
  logic [2:0]      w_low;
  logic            w_unused;

  assign w_wr       = sel & we;
  assign w_wr_mask  = w_wr && (addr == 2'd0);
  assign w_wr_mode  = w_wr && (addr == 2'd1);
  assign w_wr_pend  = w_wr && (addr == 2'd2);
  assign w_wr_claim = w_wr && (addr == 2'd3);
  assign w_id       = wdata[2:0];
  assign w_id_oh    = (w_id < NSRC_ID) ? ({{(NSRC-1){1'b0}}, 1'b1} << w_id) : '0;
  assign w_rise     = irq_in & ~r_irq_d;
  assign w_act      = r_pend & r_mask;
  assign w_unused   = &{1'b0, wdata[31:NSRC]};

  // Edge-mode clear sources: W1C on PEND, and a claim of an edge source.
`ifdef INTC_PRIORITY_EN
  assign w_clr = ((w_wr_pend ? wdata[NSRC-1:0] : '0)
               | ((w_wr_claim && wdata[31]) ? w_id_oh : '0)) & r_mode;
`else
  assign w_clr = (w_wr_pend ? wdata[NSRC-1:0] : '0) & r_mode;
`endif

  // Behaviour at a MODE-write edge follows the old mode; level->edge restarts at 0 unless an edge arrives.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NSRC; i++) begin
      if (!r_mode[i]) begin
        w_pend_nxt[i] = (w_wr_mode && wdata[i]) ? w_rise[i] : irq_in[i];
      end else begin
        w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~w_clr[i]);
      end
    end
  end

  always_comb begin
    w_low = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_low = 3'(i);
    end
  end

  always_comb begin
    logic v_acc;
    v_acc = 1'b0;
    w_blk = '0;
    for (int i = 0; i < NSRC; i++) begin
      v_acc    = v_acc | r_isr[i];
      w_blk[i] = v_acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_irq_d <= '0;
    end else begin
      r_irq_d <= irq_in;
      r_pend  <= w_pend_nxt;
      if (w_wr_mask) r_mask <= wdata[NSRC-1:0];
      if (w_wr_mode) r_mode <= wdata[NSRC-1:0];
    end
  end

`ifdef INTC_PRIORITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_isr <= '0;
    end else if (w_wr_claim) begin
      r_isr <= wdata[31] ? (r_isr | w_id_oh) : (r_isr & ~w_id_oh);
    end
  end

  assign HWInt = w_act & ~w_blk;
`else
  assign r_isr = '0;
  assign HWInt = w_act & ~w_blk;
`endif

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr)
        2'd0: rdata = 32'(r_mask);
        2'd1: rdata = 32'(r_mode);
        2'd2: rdata = 32'(r_pend);
`ifdef INTC_PRIORITY_EN
        2'd3: rdata = {|w_act, 28'd0, w_low};
`else
        2'd3: rdata = 32'd0;
`endif
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// against a behavioural model; priority checks follow INTC_PRIORITY_EN.
module tb_int_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  HWInt;

  int total = 0;
  int bad   = 0;

  logic [5:0] m_mask, m_mode, m_pend, m_irqd, m_isr;

  int_ctrl #(.NSRC(6)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .sel(sel), .addr(addr),
    .we(we), .wdata(wdata), .rdata(rdata), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic model_clear();
    m_mask = '0; m_mode = '0; m_pend = '0; m_irqd = '0; m_isr = '0;
  endtask

  // Reference behaviour for one clock edge, taken from the current inputs.
  task automatic model_edge();
    logic [5:0] np;
    logic       wr;
    wr = sel && we;
    for (int i = 0; i < 6; i++) begin
      logic rise, to_edge, clr;
      rise    = irq_in[i] && !m_irqd[i];
      to_edge = wr && addr == 2'd1 && wdata[i];
      clr     = wr && addr == 2'd2 && wdata[i];
`ifdef INTC_PRIORITY_EN
      if (wr && addr == 2'd3 && wdata[31] && int'(wdata[2:0]) == i) clr = 1'b1;
`endif
      if (m_mode[i] == 1'b0) np[i] = to_edge ? rise : irq_in[i];
      else if (rise)         np[i] = 1'b1;
      else if (clr)          np[i] = 1'b0;
      else                   np[i] = m_pend[i];
    end
`ifdef INTC_PRIORITY_EN
    if (wr && addr == 2'd3 && int'(wdata[2:0]) < 6) m_isr[wdata[2:0]] = wdata[31];
`endif
    if (wr && addr == 2'd0) m_mask = wdata[5:0];
    if (wr && addr == 2'd1) m_mode = wdata[5:0];
    m_irqd = irq_in;
    m_pend = np;
  endtask

  function automatic logic [5:0] exp_hw();
    logic [5:0] e;
    for (int i = 0; i < 6; i++) begin
      e[i] = m_pend[i] && m_mask[i] && ((m_isr & 6'((2 << i) - 1)) == 6'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_rd(input logic s, input logic [1:0] a);
    logic [5:0] act;
    act = m_pend & m_mask;
    if (!s) return 32'd0;
    case (a)
      2'd0: return {26'd0, m_mask};
      2'd1: return {26'd0, m_mode};
      2'd2: return {26'd0, m_pend};
      default: begin
`ifdef INTC_PRIORITY_EN
        for (int i = 0; i < 6; i++) if (act[i]) return {1'b1, 28'd0, 3'(i)};
        return 32'd0;
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    sel = 1'b0; we = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; irq_in = '0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_clear();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b0; irq_in = 6'h3F; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL reset_hwint actual=%h required=00", HWInt); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata_nosel actual=%h required=0", rdata); end
    rd(2'd2, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_pend actual=%h required=0", r); end
    reset = 1'b1;
    step();
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL reset_mask0 actual=%h required=00", HWInt); end
    wr(2'd0, 32'h3F);
    total++; if (HWInt !== 6'h3F) begin bad++; $display("FAIL reset_mask_write actual=%h required=3f", HWInt); end
    #2 reset = 1'b0;
    model_clear();
    #1;
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL reset_async actual=%h required=00", HWInt); end
    rd(2'd0, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_async_mask actual=%h required=0", r); end
    @(posedge clk); #1;
    irq_in = '0;
    reset = 1'b1;
  endtask

  task automatic test_level();
    logic [31:0] r;
    apply_reset();
    wr(2'd0, 32'h07);
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL level_idle actual=%h required=00", HWInt); end
    irq_in = 6'h02;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (HWInt !== 6'h02) begin bad++; $display("FAIL level_on%0d actual=%h required=02", c, HWInt); end
      rd(2'd2, r);
      total++; if (r !== 32'h02) begin bad++; $display("FAIL level_pend%0d actual=%h required=02", c, r); end
      if (c == 2) irq_in = 6'h00;
    end
    step();
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL level_off actual=%h required=00", HWInt); end
  endtask

  task automatic test_edge();
    logic [31:0] r;
    apply_reset();
    wr(2'd1, 32'h04);
    wr(2'd0, 32'h04);
    irq_in = 6'h04; step();
    irq_in = 6'h00; step(); step();
    total++; if (HWInt !== 6'h04) begin bad++; $display("FAIL edge_hold actual=%h required=04", HWInt); end
    rd(2'd2, r);
    total++; if (r !== 32'h04) begin bad++; $display("FAIL edge_pend actual=%h required=04", r); end
    wr(2'd2, 32'h04);
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL edge_w1c actual=%h required=00", HWInt); end
    irq_in = 6'h04; step();
    irq_in = 6'h00; step();
    irq_in = 6'h04;
    wr(2'd2, 32'h04);
    total++; if (HWInt !== 6'h04) begin bad++; $display("FAIL edge_set_wins actual=%h required=04", HWInt); end
    irq_in = 6'h00;
  endtask

  task automatic test_mode_switch();
    apply_reset();
    wr(2'd0, 32'h01);
    irq_in = 6'h01; step();
    total++; if (HWInt !== 6'h01) begin bad++; $display("FAIL mode_level_on actual=%h required=01", HWInt); end
    wr(2'd1, 32'h01);
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL mode_to_edge_clr actual=%h required=00", HWInt); end
    step(); step();
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL mode_no_reset actual=%h required=00", HWInt); end
    irq_in = 6'h00; step();
    irq_in = 6'h01; step();
    total++; if (HWInt !== 6'h01) begin bad++; $display("FAIL mode_new_edge actual=%h required=01", HWInt); end
    wr(2'd1, 32'h00);
    total++; if (HWInt !== 6'h01) begin bad++; $display("FAIL mode_to_level_edge actual=%h required=01", HWInt); end
    irq_in = 6'h00; step();
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL mode_level_follow actual=%h required=00", HWInt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    apply_reset();
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFEA);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd0, r);
    total++; if (r !== 32'h3F) begin bad++; $display("FAIL b2b_mask actual=%h required=3f", r); end
    rd(2'd1, r);
    total++; if (r !== 32'h2A) begin bad++; $display("FAIL b2b_mode actual=%h required=2a", r); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      irq_in = 6'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sel = 1'b1; we = 1'b1; addr = 2'($urandom);
        wdata = $urandom;
        if (addr == 2'd0 && $urandom_range(0, 1) == 1) wdata = 32'h3F;
      end else begin
        sel = 1'($urandom); we = 1'b0; addr = 2'($urandom); wdata = $urandom;
      end
      #1;
      e = exp_rd(sel, addr);
      total++; if (rdata !== e) begin bad++; $display("FAIL rand_rdata cyc=%0d addr=%0d actual=%h required=%h", c, addr, rdata, e); end
      step();
      total++; if (HWInt !== exp_hw()) begin bad++; $display("FAIL rand_hwint cyc=%0d actual=%h required=%h", c, HWInt, exp_hw()); end
    end
    sel = 1'b0; we = 1'b0; irq_in = '0;
  endtask

`ifdef INTC_PRIORITY_EN
  task automatic test_nesting();
    logic [31:0] r;
    apply_reset();
    wr(2'd1, 32'h0B);
    wr(2'd0, 32'h0B);
    irq_in = 6'h0A; step();
    irq_in = 6'h00; step();
    total++; if (HWInt !== 6'h0A) begin bad++; $display("FAIL nest_pending actual=%h required=0a", HWInt); end
    rd(2'd3, r);
    total++; if (r !== 32'h8000_0001) begin bad++; $display("FAIL nest_claim_rd actual=%h required=80000001", r); end
    wr(2'd3, 32'h8000_0001);
    total++; if (HWInt !== 6'h00) begin bad++; $display("FAIL nest_blocked actual=%h required=00", HWInt); end
    irq_in = 6'h01; step();
    irq_in = 6'h00;
    total++; if (HWInt !== 6'h01) begin bad++; $display("FAIL nest_preempt actual=%h required=01", HWInt); end
    wr(2'd3, 32'h0000_0001);
    total++; if (HWInt !== 6'h09) begin bad++; $display("FAIL nest_complete actual=%h required=09", HWInt); end
    wr(2'd3, 32'h8000_0007);
    total++; if (HWInt !== 6'h09) begin bad++; $display("FAIL nest_bad_id actual=%h required=09", HWInt); end
  endtask
`else
  task automatic test_claim_off();
    logic [31:0] r;
    apply_reset();
    wr(2'd1, 32'h02);
    wr(2'd0, 32'h02);
    irq_in = 6'h02; step();
    irq_in = 6'h00; step();
    rd(2'd3, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL off_claim_rd actual=%h required=0", r); end
    wr(2'd3, 32'h8000_0000);
    wr(2'd3, 32'h8000_0001);
    total++; if (HWInt !== 6'h02) begin bad++; $display("FAIL off_claim_hw actual=%h required=02", HWInt); end
    rd(2'd2, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL off_claim_pend actual=%h required=02", r); end
  endtask
`endif

  initial begin
    reset = 1'b0; irq_in = '0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #1;
    test_reset();
    test_level();
    test_edge();
    test_mode_switch();
    test_back_to_back();
`ifdef INTC_PRIORITY_EN
    test_nesting();
`else
    test_claim_off();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
